// File: rtl/freq_code_detector_pkg.sv
// Shared constants, FSM state type and the period-to-code decode for freq_code_detector.
// Pure combinational helpers; no clocking or flow control here.
package freq_code_detector_pkg;

   localparam int PERIOD_UNIT = 32;
   localparam int MAX_PERIOD  = 512;
   localparam int CNT_W       = 10;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   typedef struct packed {
      logic       good;
      logic [3:0] code;
   } meas_t;

   // Round P to the nearest multiple of 32, then accept it only if it lands within tol.
   function automatic meas_t decode(input cnt_t p, input logic [3:0] tol);
      logic [10:0] q;
      logic [11:0] nom;
      logic [11:0] dev;
      meas_t       m;
      q      = ({1'b0, p} + 11'd16) >> 5;
      nom    = {q[6:0], 5'b0};
      dev    = (nom >= {2'b0, p}) ? (nom - {2'b0, p}) : ({2'b0, p} - nom);
      m.good = (q >= 11'd1) && (q <= 11'd16) && (dev <= {8'b0, tol});
      m.code = 4'd0 - q[3:0];
      return m;
   endfunction

endpackage

// File: rtl/freq_code_detector_if.sv
// Pulse input and recovered-code outputs of freq_code_detector; no backpressure on either side.
interface freq_code_detector_if;

   logic       pulse_in;
   logic       h_l;
   logic [2:0] sw;
   logic       valid;
   logic       err;
   logic       locked;

   modport master (output pulse_in, input h_l, sw, valid, err, locked);
   modport slave  (input pulse_in, output h_l, sw, valid, err, locked);

endinterface

// File: rtl/freq_code_detector_period_meter.sv
// Rising-edge detector and period counter; presents P combinationally in the rise cycle.
// Timeout flags the cycle the count would reach MAX_PERIOD+TOL+1; no backpressure.
module freq_code_detector_period_meter
   import freq_code_detector_pkg::*;
#(
   parameter int TOL = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic pulse_in,
   input  logic run,
   output cnt_t period,
   output logic strobe,
   output logic timeout
);

   logic pulse_d;
   cnt_t cnt;
   logic rise;

   assign rise    = pulse_in & ~pulse_d;
   assign period  = cnt;
   assign strobe  = rise;
   // A rise in the same cycle wins, so a period of exactly MAX_PERIOD+TOL is still measured.
   assign timeout = run & ~rise & (cnt == cnt_t'(MAX_PERIOD + TOL));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pulse_d <= 1'b0;
         cnt     <= '0;
      end else begin
         pulse_d <= pulse_in;
         if (rise) begin
            cnt <= cnt_t'(1);
         end else if (run) begin
            cnt <= cnt + cnt_t'(1);
         end
      end
   end

endmodule

// File: rtl/freq_code_detector.sv
// Recovers the 4-bit divider code {h_l, sw} from the carry-out pulse period with a lock qualifier.
// valid/err/code appear one cycle after the rise cycle; free-running input, no backpressure.
module freq_code_detector
   import freq_code_detector_pkg::*;
#(
   parameter int TOL      = 2,
   parameter int LOCK_CNT = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   freq_code_detector_if.slave   link
);

   localparam logic [2:0] LOCK_N = 3'(LOCK_CNT);

   state_t     state, state_nxt;
   logic [2:0] mcnt, mcnt_nxt;
   logic [3:0] code, code_nxt;
   logic       valid_q, valid_nxt;
   logic       err_q, err_nxt;

   cnt_t  period;
   logic  strobe;
   logic  timeout;
   meas_t meas;

   freq_code_detector_period_meter #(
      .TOL (TOL)
   ) u_period_meter (
      .clk      (clk),
      .rst      (rst),
      .pulse_in (link.pulse_in),
      .run      (state != IDLE),
      .period   (period),
      .strobe   (strobe),
      .timeout  (timeout)
   );

   assign meas = decode(period, 4'(TOL));

   always_comb begin
      state_nxt = state;
      mcnt_nxt  = mcnt;
      code_nxt  = code;
      valid_nxt = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (strobe) begin
               state_nxt = ACQUIRE;
               mcnt_nxt  = 3'd0;
            end
         end
         ACQUIRE, LOCKED: begin
            if (strobe) begin
               if (meas.good) begin
                  valid_nxt = 1'b1;
                  code_nxt  = meas.code;
                  if (state == LOCKED) begin
                     if (meas.code != code) begin
                        state_nxt = ACQUIRE;
                        mcnt_nxt  = 3'd1;
                     end
                  end else begin
                     // The compare is against the code currently on the outputs.
                     if (meas.code == code) begin
                        mcnt_nxt = (mcnt == 3'd7) ? mcnt : mcnt + 3'd1;
                     end else begin
                        mcnt_nxt = 3'd1;
                     end
                     if (mcnt_nxt >= LOCK_N) begin
                        state_nxt = LOCKED;
                     end
                  end
               end else begin
                  err_nxt   = 1'b1;
                  mcnt_nxt  = 3'd0;
                  state_nxt = ACQUIRE;
               end
            end else if (timeout) begin
               err_nxt   = 1'b1;
               mcnt_nxt  = 3'd0;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            mcnt_nxt  = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         mcnt    <= 3'd0;
         code    <= 4'd0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         mcnt    <= mcnt_nxt;
         code    <= code_nxt;
         valid_q <= valid_nxt;
         err_q   <= err_nxt;
      end
   end

   assign link.h_l    = code[3];
   assign link.sw     = code[2:0];
   assign link.valid  = valid_q;
   assign link.err    = err_q;
   assign link.locked = (state == LOCKED);

endmodule
